mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised successor to the pipeline memory stage.
- Drives an external data memory over a variable-latency req/ack handshake instead of a fixed-latency single-cycle RAM.
- Generates byte enables and aligns store data; sign/zero-extends loads; detects misaligned accesses.
- Stalls upstream while an access is outstanding; registers all MEM/WB outputs.

Parameters:
- WORD_SIZE, 32, datapath width; must be 32 or 64.
- NUM_REGS, 32, register file entries.
- REG_SEL, $clog2(NUM_REGS), rd width.
- ADDR_SIZE, 10, byte-address width presented to memory.
- BE_W, WORD_SIZE/8, byte-enable width.
- TIMEOUT_CYCLES, 64, ack wait limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  EX/MEM stage holds a valid instruction.
- result  in  WORD_SIZE  ALU result / effective byte address.
- save_data  in  WORD_SIZE  store data (rs2).
- rd  in  REG_SEL  destination register.
- reg_write, mem_read, mem_write  in  1 each  control bits.
- data_sign  in  1  0 = signed, 1 = unsigned load.
- data_size  in  2  00 = byte, 01 = half, 10 = word, 11 = dword (WORD_SIZE=64 only).
- stall  out  1  upstream must hold its inputs.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_SIZE  word-aligned address.
- mem_be  out  BE_W  byte enables.
- mem_wdata  out  WORD_SIZE  lane-shifted store data.
- mem_rdata  in  WORD_SIZE  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion.
- wb_valid  out  1  WB outputs valid this cycle.
- reg_write_out  out  1  write-back enable.
- rd_out  out  REG_SEL  destination register.
- result_out  out  WORD_SIZE  registered result.
- read_data  out  WORD_SIZE  extended load data.
- misalign_out  out  1  exception flag for this instruction.
- bus_err_out  out  1  timeout flag (0 when feature off).

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- Reset: FSM to IDLE. All outputs 0, including stall, mem_req, wb_valid and the flags; mem_addr/mem_be/mem_wdata are 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, in_valid with no memory op: capture fields. Next cycle wb_valid=1 with registered values. Latency 1, no stall.
- IDLE, in_valid with memory op and aligned address: capture the op and go to ACCESS. stall is combinationally 1 from this cycle until the cycle the DONE write-back occurs.
- IDLE, in_valid with memory op and misaligned address:
  - Misaligned means half with addr[0]!=0, word with addr[1:0]!=0, dword with addr[2:0]!=0.
  - No memory request is issued.
  - Next cycle: wb_valid=1, misalign_out=1, reg_write_out=0.
- ACCESS: mem_req=1, with mem_we/mem_addr/mem_be/mem_wdata held stable until mem_ack. On mem_ack, latch mem_rdata and go to DONE.
- DONE: wb_valid=1 for exactly one cycle, stall=0, then return to IDLE. A new instruction may be accepted in the same cycle, making the exit from DONE equivalent to IDLE acceptance.
- Byte enables and store data:
  - byte: mem_be = 1 << addr_lo.
  - half: mem_be = 2'b11 << addr_lo.
  - word: mem_be = 4'hF << addr_lo.
  - dword: all ones.
  - mem_wdata = save_data << (8*addr_lo).
  - addr_lo = addr[$clog2(BE_W)-1:0].
- Loads: extract the lane by shifting mem_rdata right by 8*addr_lo, then sign-extend (data_sign=0) or zero-extend (data_sign=1) from the access size.
- Stores: reg_write_out=0 regardless of the input reg_write. read_data=0 for non-loads.
- mem_ack outside ACCESS is ignored.
- rst in ACCESS aborts the access: mem_req drops the next cycle and no wb_valid is produced.
- If mem_read and mem_write are both set, the store wins.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A cycle counter runs in ACCESS and clears on entry.
  - If TIMEOUT_CYCLES elapse without mem_ack: drop mem_req, go to DONE with bus_err_out=1 and reg_write_out=0.
  - A mem_ack arriving on the same cycle as the timeout wins.
- Undefined: no counter; ACCESS waits indefinitely; bus_err_out tied 0.

Decomposition:
- Package mem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD;
  - FSM state enum;
  - helper function for misalignment check.
- Sub-module load_align: combinational lane select plus extension (mem_rdata, addr_lo, data_size, data_sign to read_data). Shared with the future instruction-fetch path.

Test Plan:
- ALU op: result=0x1234, rd=5, reg_write=1, no mem op -> next cycle wb_valid=1, result_out=0x1234, rd_out=5, stall never asserted.
- Byte store: save_data=0xAB, addr=0x003 -> mem_be=4'b1000, mem_wdata=0xAB000000, mem_req held through 3 wait cycles, wb_valid one cycle after ack, reg_write_out=0.
- Signed half load: addr=0x002, mem_rdata=0x8001_0000 -> read_data=0xFFFF8001; same with data_sign=1 -> 0x00008001.
- Word load at addr=0x006 -> no mem_req, misalign_out=1, reg_write_out=0 next cycle.
- rst asserted mid-ACCESS, then ack arrives -> mem_req 0 the following cycle, no wb_valid, all outputs 0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never sent -> mem_req drops after 4 cycles, bus_err_out=1 with wb_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the memory access unit and its load aligner.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  function automatic logic is_misaligned(input logic [2:0] addr, input logic [1:0] size);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr[0];
      SZ_WORD: mis = |addr[1:0];
      default: mis = |addr[2:0];
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load lane select plus sign/zero extension (module load_align),
// shared by the data path and the future instruction-fetch path.
module load_align import mem_pkg::*; #(
  parameter int WORD_SIZE = 32,
  parameter int LO_W      = $clog2(WORD_SIZE/8)
) (
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic [LO_W-1:0]      addr_lo,
  input  logic [1:0]           data_size,
  input  logic                 data_sign,
  output logic [WORD_SIZE-1:0] read_data
);

  logic [WORD_SIZE-1:0] lane;
  logic [WORD_SIZE-1:0] top;
  logic [6:0]           pad;

  // Bring the addressed lane to bit 0, park its MSB at the top, then shift back to extend.
  always_comb begin
    lane = mem_rdata >> {addr_lo, 3'b000};
    case (data_size)
      SZ_BYTE: pad = 7'(WORD_SIZE - 8);
      SZ_HALF: pad = 7'(WORD_SIZE - 16);
      SZ_WORD: pad = 7'(WORD_SIZE - 32);
      default: pad = 7'd0;
    endcase
    top = lane << pad;
    if (data_sign) begin
      read_data = top >> pad;
    end else begin
      read_data = $signed(top) >>> pad;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory stage driving a variable-latency req/ack data memory.
// Optional ack timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit import mem_pkg::*; #(
  parameter int WORD_SIZE      = 32,
  parameter int NUM_REGS       = 32,
  parameter int REG_SEL        = $clog2(NUM_REGS),
  parameter int ADDR_SIZE      = 10,
  parameter int BE_W           = WORD_SIZE/8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] result,
  input  logic [WORD_SIZE-1:0] save_data,
  input  logic [REG_SEL-1:0]   rd,
  input  logic                 reg_write,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 data_sign,
  input  logic [1:0]           data_size,
  output logic                 stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [BE_W-1:0]      mem_be,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 wb_valid,
  output logic                 reg_write_out,
  output logic [REG_SEL-1:0]   rd_out,
  output logic [WORD_SIZE-1:0] result_out,
  output logic [WORD_SIZE-1:0] read_data,
  output logic                 misalign_out,
  output logic                 bus_err_out
);

  localparam int LO_W = $clog2(BE_W);

  state_t state, next_state;
  logic accept, start_access, complete, timeout, bus_err_now;
  logic mem_op, mis;
  logic [LO_W-1:0]      addr_lo;
  logic [BE_W-1:0]      be;
  logic                 cap_store, cap_load, cap_sign, cap_reg_write;
  logic [1:0]           cap_size;
  logic [LO_W-1:0]      cap_lo;
  logic [REG_SEL-1:0]   cap_rd;
  logic [WORD_SIZE-1:0] cap_result, load_data;

  assign mem_op      = mem_read | mem_write;
  assign mis         = is_misaligned(result[2:0], data_size);
  assign addr_lo     = result[LO_W-1:0];
  assign bus_err_now = timeout & ~mem_ack;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Cycles spent waiting for ack in the current access.
  always_ff @(posedge clk) begin
    if (rst || start_access) begin
      wait_cnt <= {CNT_W{1'b0}};
    end else if (state == ACCESS) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  assign timeout = (state == ACCESS) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and handshake decode; DONE accepts a new instruction exactly like IDLE.
  always_comb begin
    next_state   = state;
    accept       = 1'b0;
    start_access = 1'b0;
    complete     = 1'b0;
    stall        = 1'b0;
    case (state)
      IDLE, DONE: begin
        accept = in_valid;
        if (in_valid && mem_op && !mis) begin
          start_access = 1'b1;
          stall        = 1'b1;
          next_state   = ACCESS;
        end else begin
          next_state = IDLE;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem_ack || timeout) begin
          complete   = 1'b1;
          next_state = DONE;
        end else begin
          next_state = ACCESS;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Byte enables from access size and low address bits.
  always_comb begin
    case (data_size)
      SZ_BYTE: be = BE_W'(1'b1) << addr_lo;
      SZ_HALF: be = BE_W'(2'b11) << addr_lo;
      SZ_WORD: be = BE_W'(4'hF) << addr_lo;
      default: be = {BE_W{1'b1}};
    endcase
  end

  load_align #(.WORD_SIZE(WORD_SIZE), .LO_W(LO_W)) u_load_align (
    .mem_rdata (mem_rdata),
    .addr_lo   (cap_lo),
    .data_size (cap_size),
    .data_sign (cap_sign),
    .read_data (load_data)
  );

  // Captured op fields, memory bus registers and write-back registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      {cap_store, cap_load, cap_sign, cap_reg_write} <= 4'b0000;
      cap_size      <= 2'b00;
      cap_lo        <= {LO_W{1'b0}};
      cap_rd        <= {REG_SEL{1'b0}};
      cap_result    <= {WORD_SIZE{1'b0}};
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= {ADDR_SIZE{1'b0}};
      mem_be        <= {BE_W{1'b0}};
      mem_wdata     <= {WORD_SIZE{1'b0}};
      wb_valid      <= 1'b0;
      reg_write_out <= 1'b0;
      rd_out        <= {REG_SEL{1'b0}};
      result_out    <= {WORD_SIZE{1'b0}};
      read_data     <= {WORD_SIZE{1'b0}};
      misalign_out  <= 1'b0;
      bus_err_out   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept) begin
        cap_store     <= mem_write;
        cap_load      <= mem_read & ~mem_write;
        cap_sign      <= data_sign;
        cap_reg_write <= reg_write;
        cap_size      <= data_size;
        cap_lo        <= addr_lo;
        cap_rd        <= rd;
        cap_result    <= result;
      end
      if (start_access) begin
        mem_req   <= 1'b1;
        mem_we    <= mem_write;
        mem_addr  <= {result[ADDR_SIZE-1:LO_W], {LO_W{1'b0}}};
        mem_be    <= be;
        mem_wdata <= save_data << {addr_lo, 3'b000};
      end else if (complete) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= {ADDR_SIZE{1'b0}};
        mem_be    <= {BE_W{1'b0}};
        mem_wdata <= {WORD_SIZE{1'b0}};
      end
      if (accept && !start_access) begin
        wb_valid      <= 1'b1;
        reg_write_out <= reg_write & ~(mem_op & mis) & ~mem_write;
        rd_out        <= rd;
        result_out    <= result;
        read_data     <= {WORD_SIZE{1'b0}};
        misalign_out  <= mem_op & mis;
        bus_err_out   <= 1'b0;
      end else if (complete) begin
        wb_valid      <= 1'b1;
        reg_write_out <= cap_reg_write & ~cap_store & ~bus_err_now;
        rd_out        <= cap_rd;
        result_out    <= cap_result;
        read_data     <= (cap_load && !bus_err_now) ? load_data : {WORD_SIZE{1'b0}};
        misalign_out  <= 1'b0;
        bus_err_out   <= bus_err_now;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus write-back scoreboard.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, reg_write, mem_read, mem_write, data_sign, mem_ack;
  logic [31:0] result, save_data, mem_rdata;
  logic [4:0]  rd;
  logic [1:0]  data_size;
  logic        stall, mem_req, mem_we, wb_valid, reg_write_out, misalign_out, bus_err_out;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, result_out, read_data;
  logic [4:0]  rd_out;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        rw;
    logic [31:0] rdata;
    logic        mis;
    logic        berr;
  } wb_t;

  typedef struct {
    logic [31:0] result, save, rdata;
    logic [4:0]  rd;
    logic        rw, mr, mw, sign;
    logic [1:0]  size;
    int          waits;
    logic        req;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rw_exp;
    logic [31:0] rdx;
    logic        mis;
  } vec_t;

  wb_t  sb[$];
  wb_t  exp_wb, got_wb;
  vec_t vecs[12];

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .result(result), .save_data(save_data),
    .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .data_sign(data_sign), .data_size(data_size), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid),
    .reg_write_out(reg_write_out), .rd_out(rd_out), .result_out(result_out),
    .read_data(read_data), .misalign_out(misalign_out), .bus_err_out(bus_err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write-back must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      total = total + 1;
      if (sb.size() == 0) begin
        bad = bad + 1;
        $display("FAIL wb_unexpected: got wb_valid=1 want no write-back");
      end else begin
        exp_wb = sb.pop_front();
        got_wb = {rd_out, result_out, reg_write_out, read_data, misalign_out, bus_err_out};
        if (got_wb !== exp_wb) begin
          bad = bad + 1;
          $display("FAIL wb: got rd=%0d res=%h rw=%b rdata=%h mis=%b berr=%b want rd=%0d res=%h rw=%b rdata=%h mis=%b berr=%b",
                   got_wb.rd, got_wb.res, got_wb.rw, got_wb.rdata, got_wb.mis, got_wb.berr,
                   exp_wb.rd, exp_wb.res, exp_wb.rw, exp_wb.rdata, exp_wb.mis, exp_wb.berr);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] r, input logic [31:0] s, input logic [4:0] d,
                       input logic rw, input logic mr, input logic mw, input logic sg,
                       input logic [1:0] sz);
    in_valid = 1'b1; result = r; save_data = s; rd = d; reg_write = rw;
    mem_read = mr; mem_write = mw; data_sign = sg; data_size = sz;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v.result, v.save, v.rd, v.rw, v.mr, v.mw, v.sign, v.size);
    sb.push_back({v.rd, v.result, v.rw_exp, v.rdx, v.mis, 1'b0});
    #1 check("accept_stall", 64'(stall), 64'(v.req));
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (v.req) begin
      for (int i = 0; i <= v.waits; i++) begin
        @(negedge clk);
        check("mem_req", 64'(mem_req), 64'd1);
        check("access_stall", 64'(stall), 64'd1);
        check("mem_we", 64'(mem_we), 64'(v.mw));
        check("mem_addr", 64'(mem_addr), 64'({v.result[9:2], 2'b00}));
        check("mem_be", 64'(mem_be), 64'(v.be));
        check("mem_wdata", 64'(mem_wdata), 64'(v.wdata));
        if (i == v.waits) begin
          mem_ack = 1'b1;
          mem_rdata = v.rdata;
        end
      end
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = $urandom();
      check("req_drop", 64'(mem_req), 64'd0);
      check("done_stall", 64'(stall), 64'd0);
    end else begin
      @(negedge clk);
      check("no_req", 64'(mem_req), 64'd0);
    end
  endtask

  initial begin
    // result, save, rdata, rd, rw, mr, mw, sign, size, waits, req, be, wdata, rw_exp, rdx, mis
    vecs[0]  = '{32'h1234, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0};
    vecs[1]  = '{32'h003, 32'hAB, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3, 1'b1, 4'b1000, 32'hAB000000, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{32'h002, 32'h0, 32'h80010000, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 0, 1'b1, 4'b1100, 32'h0, 1'b1, 32'hFFFF8001, 1'b0};
    vecs[3]  = '{32'h002, 32'h0, 32'h80010000, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1, 1'b1, 4'b1100, 32'h0, 1'b1, 32'h00008001, 1'b0};
    vecs[4]  = '{32'h006, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1};
    vecs[5]  = '{32'h101, 32'h0, 32'h00008000, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1, 1'b1, 4'b0010, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0};
    vecs[6]  = '{32'h3FC, 32'hDEADBEEF, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 2, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
    vecs[7]  = '{32'h011, 32'h5555, 32'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b1};
    vecs[8]  = '{32'h012, 32'h1234, 32'hFFFFFFFF, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1, 1'b1, 4'b1100, 32'h12340000, 1'b0, 32'h0, 1'b0};
    vecs[9]  = '{32'h020, 32'h0, 32'hCAFEF00D, 5'd14, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 0, 1'b1, 4'hF, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0};
    vecs[10] = '{32'h003, 32'h0, 32'hF0000000, 5'd15, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2, 1'b1, 4'b1000, 32'h0, 1'b1, 32'h000000F0, 1'b0};
    vecs[11] = '{32'hFFFFFFFF, 32'h0, 32'h0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h5A5A5A5A;
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 64'({stall, mem_req, mem_we, wb_valid, reg_write_out, misalign_out, bus_err_out}), 64'd0);
    check("rst_mem", 64'({mem_addr, mem_be, mem_wdata}), 64'd0);
    check("rst_wb", 64'({rd_out, read_data}), 64'd0);
    check("rst_res", 64'(result_out), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Back-to-back: new ALU op accepted during the DONE cycle of a load.
    @(negedge clk);
    drive(32'h000, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
    sb.push_back({5'd2, 32'h0, 1'b1, 32'h0000BEEF, 1'b0, 1'b0});
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1111BEEF;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    drive(32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
    sb.push_back({5'd3, 32'h55, 1'b1, 32'h0, 1'b0, 1'b0});
    #1 check("done_accept_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);

    // Reset during ACCESS, then a stray ack: nothing may come out.
    @(negedge clk);
    drive(32'h040, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("abort_req_before", 64'(mem_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_req_after", 64'(mem_req), 64'd0);
    check("abort_stall", 64'(stall), 64'd0);
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 1'b0;
    check("abort_ctrl", 64'({stall, mem_req, mem_we, wb_valid, reg_write_out, misalign_out, bus_err_out}), 64'd0);
    check("abort_mem", 64'({mem_addr, mem_be, mem_wdata}), 64'd0);
    check("abort_wb", 64'({rd_out, read_data}), 64'd0);

`ifdef MEM_TIMEOUT_EN
    // No ack: four request cycles, then a bus-error write-back.
    @(negedge clk);
    drive(32'h080, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
    sb.push_back({5'd6, 32'h080, 1'b0, 32'h0, 1'b0, 1'b1});
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("to_req", 64'(mem_req), 64'd1);
    end
    @(negedge clk);
    check("to_drop", 64'(mem_req), 64'd0);
    check("to_berr", 64'(bus_err_out), 64'd1);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
